// File: rtl/cnn_layer_accel_awe_weight_arbiter.sv
// Round-robin arbiter sharing one weight-distributor read lane among C_NUM_REQ AWE requesters.
// Optional AWE_WEIGHT_ARB_BACK_TO_BACK_EN: drops the drain phase so bursts chain with no idle cycle.
module cnn_layer_accel_awe_weight_arbiter #(
   parameter int C_NUM_REQ      = 4,
   parameter int C_REQ_ID_WIDTH = 2,
   parameter int C_BURST_WIDTH  = 8,
   parameter int C_RD_LATENCY   = 2,
   parameter int C_WEIGHT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_valid,
   input  logic [C_BURST_WIDTH-1:0]    cfg_burst_len,
   input  logic [C_NUM_REQ-1:0]        req,
   output logic [C_NUM_REQ-1:0]        grant,
   output logic                        busy,
   output logic                        dist_req_valid,
   input  logic                        dist_weight_valid,
   input  logic [2*C_WEIGHT_WIDTH-1:0] dist_weight_data,
   output logic [C_NUM_REQ-1:0]        wt_valid,
   output logic [2*C_WEIGHT_WIDTH-1:0] wt_data,
   output logic [C_NUM_REQ-1:0]        burst_done,
   output logic                        tag_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_BURST, ST_DRAIN} state_t;

   typedef struct packed {
      logic                      vld;
      logic [C_REQ_ID_WIDTH-1:0] id;
   } tag_t;

   state_t                    state, state_nxt;
   logic [C_BURST_WIDTH-1:0]  burst_len;
   logic [C_BURST_WIDTH-1:0]  beat_cnt;
   logic [C_REQ_ID_WIDTH-1:0] rr_ptr;
   logic [C_REQ_ID_WIDTH-1:0] owner;
   tag_t [C_RD_LATENCY-1:0]   tag_pipe;
   tag_t                      tail;

   logic                      arb_found;
   logic [C_REQ_ID_WIDTH-1:0] arb_win;
   logic [C_REQ_ID_WIDTH-1:0] arb_next_ptr;
   logic [C_NUM_REQ-1:0]      arb_onehot;
   logic                      issue;
   logic                      last_beat;
   logic [C_NUM_REQ-1:0]      route;

`ifndef AWE_WEIGHT_ARB_BACK_TO_BACK_EN
   localparam int DCW = $clog2(C_RD_LATENCY + 1);
   logic [DCW-1:0] drain_cnt;
`endif

   // Rotating-priority search: first set req bit at or above rr_ptr, wrapping.
   always_comb begin : p_arb
      int idx;
      idx        = 0;
      arb_found  = 1'b0;
      arb_win    = '0;
      arb_onehot = '0;
      for (int i = 0; i < C_NUM_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % C_NUM_REQ;
         if (!arb_found && req[C_REQ_ID_WIDTH'(idx)]) begin
            arb_found = 1'b1;
            arb_win   = C_REQ_ID_WIDTH'(idx);
         end
      end
      for (int i = 0; i < C_NUM_REQ; i++)
         arb_onehot[i] = arb_found && (int'(arb_win) == i);
      arb_next_ptr = (int'(arb_win) == C_NUM_REQ - 1) ? '0 : arb_win + 1'b1;
   end

   assign issue     = (state == ST_BURST) && req[owner];
   assign last_beat = issue && (beat_cnt == burst_len);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (cfg_valid) state_nxt = ST_ARB;
         ST_ARB:   if (arb_found) state_nxt = ST_BURST;
         ST_BURST: begin
            if (last_beat) begin
`ifdef AWE_WEIGHT_ARB_BACK_TO_BACK_EN
               state_nxt = arb_found ? ST_BURST : ST_ARB;
`else
               state_nxt = ST_DRAIN;
`endif
            end
         end
`ifndef AWE_WEIGHT_ARB_BACK_TO_BACK_EN
         ST_DRAIN: if (drain_cnt == DCW'(C_RD_LATENCY - 1)) state_nxt = ST_ARB;
`endif
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy           = (state != ST_IDLE);
      dist_req_valid = issue;
      burst_done     = last_beat ? grant : '0;
   end

   // Burst bookkeeping; grant is registered so it lags arbitration by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_len <= '0;
         beat_cnt  <= '0;
         rr_ptr    <= '0;
         owner     <= '0;
         grant     <= '0;
`ifndef AWE_WEIGHT_ARB_BACK_TO_BACK_EN
         drain_cnt <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (cfg_valid) burst_len <= cfg_burst_len;
            ST_ARB: begin
               if (arb_found) begin
                  grant    <= arb_onehot;
                  owner    <= arb_win;
                  rr_ptr   <= arb_next_ptr;
                  beat_cnt <= '0;
               end
            end
            ST_BURST: begin
               if (last_beat) begin
`ifdef AWE_WEIGHT_ARB_BACK_TO_BACK_EN
                  // Next owner is chosen on the final beat so its first beat follows directly.
                  grant    <= arb_onehot;
                  beat_cnt <= '0;
                  if (arb_found) begin
                     owner  <= arb_win;
                     rr_ptr <= arb_next_ptr;
                  end
`else
                  grant     <= '0;
                  drain_cnt <= '0;
`endif
               end else if (issue) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
`ifndef AWE_WEIGHT_ARB_BACK_TO_BACK_EN
            ST_DRAIN: drain_cnt <= drain_cnt + 1'b1;
`endif
            default: ;
         endcase
      end
   end

   // Tag pipe mirrors distributor latency so each returning beat knows its owner.
   assign tail = tag_pipe[C_RD_LATENCY-1];

   always_comb begin
      for (int i = 0; i < C_NUM_REQ; i++)
         route[i] = dist_weight_valid && tail.vld && (int'(tail.id) == i);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_pipe <= '0;
         wt_valid <= '0;
         wt_data  <= '0;
         tag_err  <= 1'b0;
      end else begin
         tag_pipe[0] <= '{vld: issue, id: owner};
         for (int i = 1; i < C_RD_LATENCY; i++)
            tag_pipe[i] <= tag_pipe[i-1];
         wt_valid <= route;
         if (dist_weight_valid && tail.vld) wt_data <= dist_weight_data;
         if (dist_weight_valid && !tail.vld) tag_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cnn_layer_accel_awe_weight_arbiter.sv
// Self-checking bench: randomized and directed stimulus against a transaction-level arbiter model.
module tb_cnn_layer_accel_awe_weight_arbiter;
   localparam int N = 4, IDW = 2, BW = 8, L = 2, WW = 8, DW = 2 * WW;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid;
   logic [BW-1:0] cfg_burst_len;
   logic [N-1:0]  req;
   logic [N-1:0]  grant;
   logic          busy;
   logic          dist_req_valid;
   logic          dist_weight_valid;
   logic [DW-1:0] dist_weight_data;
   logic [N-1:0]  wt_valid;
   logic [DW-1:0] wt_data;
   logic [N-1:0]  burst_done;
   logic          tag_err;

   always #5 clk = ~clk;

   cnn_layer_accel_awe_weight_arbiter #(
      .C_NUM_REQ(N), .C_REQ_ID_WIDTH(IDW), .C_BURST_WIDTH(BW),
      .C_RD_LATENCY(L), .C_WEIGHT_WIDTH(WW)
   ) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_burst_len(cfg_burst_len),
      .req(req), .grant(grant), .busy(busy), .dist_req_valid(dist_req_valid),
      .dist_weight_valid(dist_weight_valid), .dist_weight_data(dist_weight_data),
      .wt_valid(wt_valid), .wt_data(wt_data), .burst_done(burst_done), .tag_err(tag_err)
   );

   int cmp_n = 0, err_n = 0, cyc_n = 0;
   logic inj = 1'b0, sup = 1'b0;

   // Reference model: owner < 0 means no burst in progress
   bit            m_cfg;
   int            m_blen, m_owner, m_beats, m_drain, m_ptr;
   logic [N-1:0]  m_wtv;
   logic [DW-1:0] m_wtd;
   logic          m_err;
   bit            hv[L];
   int            hid[L];

   int iss_c[$], iss_id[$], wt_c[$], wt_id[$], gnt_log[$], done_c[$];
   logic [N-1:0] prev_g;

   function automatic int pick(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic int oh2i(logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_cfg = 0; m_blen = 0; m_owner = -1; m_beats = 0; m_drain = 0; m_ptr = 0;
      m_wtv = '0; m_wtd = '0; m_err = 1'b0; prev_g = '0;
      for (int i = 0; i < L; i++) begin hv[i] = 0; hid[i] = 0; end
   endtask

   task automatic clear_logs();
      iss_c.delete(); iss_id.delete(); wt_c.delete(); wt_id.delete();
      gnt_log.delete(); done_c.delete();
   endtask

   // One clock cycle: entered and left at posedge+1 with req/cfg already driven.
   task automatic cyc();
      logic [N-1:0] eg, ed;
      logic         edrv;
      int           w;
      dist_weight_valid = sup ? 1'b0 : (hv[L-1] | inj);
      dist_weight_data  = DW'($urandom);
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      edrv = (m_owner >= 0) && req[m_owner];
      ed   = (edrv && m_beats == m_blen) ? eg : '0;
      @(negedge clk);
      cmp_n++; if (grant !== eg) begin err_n++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc_n, grant, eg); end
      cmp_n++; if (dist_req_valid !== edrv) begin err_n++; $display("FAIL dist_req_valid cyc=%0d got=%b exp=%b", cyc_n, dist_req_valid, edrv); end
      cmp_n++; if (busy !== m_cfg) begin err_n++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc_n, busy, m_cfg); end
      cmp_n++; if (burst_done !== ed) begin err_n++; $display("FAIL burst_done cyc=%0d got=%b exp=%b", cyc_n, burst_done, ed); end
      cmp_n++; if (wt_valid !== m_wtv) begin err_n++; $display("FAIL wt_valid cyc=%0d got=%b exp=%b", cyc_n, wt_valid, m_wtv); end
      cmp_n++; if (wt_data !== m_wtd) begin err_n++; $display("FAIL wt_data cyc=%0d got=%h exp=%h", cyc_n, wt_data, m_wtd); end
      cmp_n++; if (tag_err !== m_err) begin err_n++; $display("FAIL tag_err cyc=%0d got=%b exp=%b", cyc_n, tag_err, m_err); end
      if (dist_req_valid) begin iss_c.push_back(cyc_n); iss_id.push_back(oh2i(grant)); end
      if (wt_valid != '0) begin wt_c.push_back(cyc_n); wt_id.push_back(oh2i(wt_valid)); end
      if (burst_done != '0) done_c.push_back(cyc_n);
      if (grant != '0 && grant != prev_g) gnt_log.push_back(oh2i(grant));
      prev_g = grant;
      // registered return path
      m_wtv = '0;
      if (dist_weight_valid && hv[L-1]) begin m_wtv[hid[L-1]] = 1'b1; m_wtd = dist_weight_data; end
      if (dist_weight_valid && !hv[L-1]) m_err = 1'b1;
      for (int i = L - 1; i > 0; i--) begin hv[i] = hv[i-1]; hid[i] = hid[i-1]; end
      hv[0] = edrv; hid[0] = (m_owner < 0) ? 0 : m_owner;
      // burst control
      if (!m_cfg) begin
         if (cfg_valid) begin m_cfg = 1; m_blen = int'(cfg_burst_len); end
      end else if (m_owner >= 0) begin
         if (edrv) begin
            if (m_beats == m_blen) begin
`ifdef AWE_WEIGHT_ARB_BACK_TO_BACK_EN
               w = pick(req, m_ptr); m_owner = w;
               if (w >= 0) begin m_ptr = (w + 1) % N; m_beats = 0; end
`else
               m_owner = -1; m_drain = L;
`endif
            end else m_beats++;
         end
      end else if (m_drain > 0) begin
         m_drain--;
      end else begin
         w = pick(req, m_ptr);
         if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % N; m_beats = 0; end
      end
      cyc_n++;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; cfg_valid = 1'b0; cfg_burst_len = '0; req = '0; inj = 1'b0; sup = 1'b0;
      dist_weight_valid = 1'b0; dist_weight_data = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset(); clear_logs();
      rst = 1'b1;
   endtask

   task automatic configure(input int blen);
      cfg_valid = 1'b1; cfg_burst_len = BW'(blen);
      cyc();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0; #2;
      cmp_n++; if ({grant, busy, dist_req_valid, wt_valid, wt_data, burst_done, tag_err} !== '0) begin
         err_n++; $display("FAIL reset_outputs got grant=%b busy=%b drv=%b wtv=%b wtd=%h done=%b err=%b",
                           grant, busy, dist_req_valid, wt_valid, wt_data, burst_done, tag_err);
      end
      @(posedge clk); #1; rst = 1'b1;
      req = 4'b1111;
      repeat (4) cyc();
   endtask

   task automatic test_single();
      int k;
      do_reset();
      configure(3);
      req = 4'b0001;
      k = 0;
      while (done_c.size() == 0 && k < 30) begin cyc(); k++; end
      req = '0;
      repeat (6) cyc();
      cmp_n++; if (iss_c.size() != 4) begin err_n++; $display("FAIL single_beats got=%0d exp=4", iss_c.size()); end
      cmp_n++; if (done_c.size() != 1 || iss_c.size() != 4 || done_c[0] != iss_c[3]) begin
         err_n++; $display("FAIL single_done_on_last_beat got=%0d pulses", done_c.size()); end
      cmp_n++; if (wt_c.size() != 4) begin err_n++; $display("FAIL single_wt_count got=%0d exp=4", wt_c.size()); end
      for (int i = 0; i < 4 && i < wt_c.size() && i < iss_c.size(); i++) begin
         cmp_n++; if (wt_c[i] - iss_c[i] != L + 1 || wt_id[i] != 0) begin
            err_n++; $display("FAIL single_wt_latency beat=%0d got=%0d id=%0d exp=%0d id=0", i, wt_c[i] - iss_c[i], wt_id[i], L + 1); end
      end
   endtask

   task automatic test_round_robin();
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      do_reset();
      configure(0);
      req = 4'b1111;
      repeat (30) cyc();
      cmp_n++; if (gnt_log.size() < 5) begin err_n++; $display("FAIL rr_grants got=%0d exp>=5", gnt_log.size()); end
      for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
         cmp_n++; if (gnt_log[i] != exp_ord[i]) begin err_n++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, gnt_log[i], exp_ord[i]); end
      end
      cmp_n++; if (iss_c.size() != gnt_log.size()) begin
         err_n++; $display("FAIL rr_one_beat_per_burst beats=%0d grants=%0d", iss_c.size(), gnt_log.size()); end
   endtask

   task automatic test_pause();
      int k;
      do_reset();
      configure(7);
      req = 4'b0100;
      k = 0;
      while (iss_c.size() < 3 && k < 20) begin cyc(); k++; end
      req = '0;
      repeat (5) cyc();
      cmp_n++; if (iss_c.size() != 3) begin err_n++; $display("FAIL pause_hold got=%0d beats exp=3", iss_c.size()); end
      req = 4'b0100;
      k = 0;
      while (done_c.size() == 0 && k < 30) begin cyc(); k++; end
      req = '0;
      repeat (5) cyc();
      cmp_n++; if (iss_c.size() != 8) begin err_n++; $display("FAIL pause_total got=%0d beats exp=8", iss_c.size()); end
      cmp_n++; if (gnt_log.size() != 1 || gnt_log[0] != 2) begin
         err_n++; $display("FAIL pause_owner grants=%0d exp single grant to 2", gnt_log.size()); end
   endtask

   task automatic test_tag_err();
      do_reset();
      inj = 1'b1;
      cyc();
      inj = 1'b0;
      repeat (4) cyc();
      cmp_n++; if (tag_err !== 1'b1 || wt_valid !== '0) begin
         err_n++; $display("FAIL tag_err_sticky got err=%b wtv=%b exp err=1 wtv=0", tag_err, wt_valid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      configure(7);
      req = 4'b0001;
      repeat (3) cyc();
      #3 rst = 1'b0;
      #1;
      cmp_n++; if ({grant, dist_req_valid, busy, wt_valid} !== '0) begin
         err_n++; $display("FAIL async_reset got grant=%b drv=%b busy=%b wtv=%b exp all 0", grant, dist_req_valid, busy, wt_valid); end
      @(posedge clk); #1;
      model_reset(); clear_logs();
      rst = 1'b1;
      req = 4'b1111;
      repeat (6) cyc();
      cmp_n++; if (iss_c.size() != 0) begin err_n++; $display("FAIL async_needs_cfg got=%0d beats exp=0", iss_c.size()); end
      configure(0);
      repeat (6) cyc();
   endtask

   task automatic test_back_to_back();
      int k, exp_gap;
      int exp_id[4] = '{0, 0, 1, 1};
`ifdef AWE_WEIGHT_ARB_BACK_TO_BACK_EN
      exp_gap = 1;
`else
      exp_gap = L + 2;
`endif
      do_reset();
      configure(1);
      req = 4'b0011;
      k = 0;
      while (done_c.size() < 2 && k < 40) begin cyc(); k++; end
      req = '0;
      repeat (6) cyc();
      cmp_n++; if (iss_c.size() != 4 || wt_c.size() != 4) begin
         err_n++; $display("FAIL b2b_counts got beats=%0d wt=%0d exp 4/4", iss_c.size(), wt_c.size()); end
      else begin
         cmp_n++; if (iss_c[2] - iss_c[1] != exp_gap) begin
            err_n++; $display("FAIL b2b_gap got=%0d exp=%0d", iss_c[2] - iss_c[1], exp_gap); end
         for (int i = 0; i < 4; i++) begin
            cmp_n++; if (iss_id[i] != exp_id[i] || wt_id[i] != exp_id[i]) begin
               err_n++; $display("FAIL b2b_route idx=%0d got iss=%0d wt=%0d exp=%0d", i, iss_id[i], wt_id[i], exp_id[i]); end
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         do_reset();
         for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            req = N'($urandom_range(0, 15)); cyc();
         end
         configure(int'($urandom_range(0, 4)));
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 2) == 0) req = N'($urandom_range(0, 15));
            sup       = ($urandom_range(0, 9) == 0);
            inj       = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 19) == 0);
            cfg_burst_len = BW'($urandom_range(0, 7));
            cyc();
         end
         sup = 1'b0; inj = 1'b0; cfg_valid = 1'b0;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_pause();
      test_tag_err();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
